if_id_pipe_reg: RTL and testbench
=================================

Name: if_id_pipe_reg

Overview:
Fetch-to-decode pipeline register. It consumes the hazard unit's Stall request and the decode-stage branch-taken signal. It holds, captures or bubbles the fetched instruction and PC+4 on behalf of the decode stage. It keeps a small control FSM and saturating stall, flush and bubble counters for pipeline performance debug.

Parameters:
DWL, 32, data width of instruction and PC+4 paths
CNTW, 16, width of each performance counter
WD_LIMIT, 64, stall-cycle limit for the optional watchdog (used only when the feature is compiled in)

Ports:
clk  in  1  pipeline clock; all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
Stall  in  1  hazard-unit stall request; hold the D-stage contents
PCSrcD  in  1  branch taken, resolved in decode; squash the instruction being fetched
InstrF  in  DWL  instruction from fetch
PCPlus4F  in  DWL  PC+4 from fetch
InstrD  out  DWL  registered instruction presented to decode
PCPlus4D  out  DWL  registered PC+4 presented to decode
ValidD  out  1  1 = InstrD is a real instruction; 0 = bubble (InstrD is all zeros, which is a MIPS nop)
StateD  out  2  FSM state: 00 RUN, 01 HOLD, 10 SQUASH
StallCnt  out  CNTW  cycles with Stall=1 since reset, saturating
FlushCnt  out  CNTW  cycles in which a squash was applied, saturating
BubbleCnt  out  CNTW  cycles with ValidD=0 after reset exit, saturating
StallTimeout  out  1  watchdog flag; tied 0 when the feature is compiled out

Behaviour:
- Reset (rst_n=0, asynchronous): InstrD=0, PCPlus4D=0, ValidD=0, StateD=RUN, all counters=0, StallTimeout=0.
- Reset release: the first rising edge with rst_n=1 evaluates normally. There is no extra dead cycle.
- Per-edge priority: Stall first, then PCSrcD, then normal capture.
- Stall=1:
  - InstrD, PCPlus4D and ValidD hold their values.
  - Next state is HOLD.
  - PCSrcD is ignored in that cycle, because the branch has not resolved while stalled.
- Stall=0, PCSrcD=1:
  - InstrD=0, PCPlus4D=PCPlus4F, ValidD=0.
  - Next state is SQUASH.
  - FlushCnt increments.
- Stall=0, PCSrcD=0:
  - InstrD=InstrF, PCPlus4D=PCPlus4F, ValidD=1.
  - Next state is RUN.
- FSM transitions, from any state:
  - Stall gives HOLD.
  - else PCSrcD gives SQUASH.
  - else RUN.
- Leaving HOLD: the held instruction advances downstream on the first edge with Stall=0. It is never duplicated and never dropped.
- Back-to-back squashes: PCSrcD on consecutive edges gives consecutive bubbles, with StateD staying in SQUASH.
- Counters:
  - StallCnt increments on each edge where Stall=1.
  - BubbleCnt increments on each edge where the registered ValidD=0.
  - All counters saturate at 2^CNTW-1. They do not wrap.
  - A counter update in the same edge as a state change uses that edge's inputs.
- Latency: 1 cycle from F inputs to D outputs when neither Stall nor PCSrcD is asserted.
- Reset mid-stall or mid-squash forces all outputs to reset values immediately, without waiting for a clock edge.

Optional Feature:
Macro IF_ID_STALL_WATCHDOG_EN.
- Defined:
  - An internal counter tracks consecutive Stall=1 edges and clears on any edge with Stall=0.
  - When the count reaches WD_LIMIT, StallTimeout sets to 1.
  - StallTimeout is sticky until rst_n=0.
  - Pipeline behaviour is otherwise unchanged; the watchdog never forces release of the stall.
- Not defined: StallTimeout is a constant 0, and no watchdog counter logic exists.

Test Plan:
- Reset then free run: InstrF=0x8C080004, PCPlus4F=0x00000004, Stall=0, PCSrcD=0 for one edge -> InstrD=0x8C080004, PCPlus4D=0x4, ValidD=1, StateD=00.
- Stall held 3 cycles while InstrF changes each cycle -> InstrD stays at its pre-stall value, StateD=01, StallCnt=3. Release -> the next InstrF is captured and exactly one old instruction reached decode.
- PCSrcD=1 with Stall=0 -> InstrD=0, ValidD=0, StateD=10, FlushCnt=1, BubbleCnt=1 on the following edge.
- Stall=1 and PCSrcD=1 together -> hold wins, FlushCnt unchanged, StateD=01.
- Assert rst_n=0 asynchronously between edges during HOLD -> all outputs return to zero and RUN immediately.
- With IF_ID_STALL_WATCHDOG_EN and WD_LIMIT=4: Stall held 4 edges -> StallTimeout=1 and it stays 1 after Stall drops. With the macro undefined, the same stimulus leaves StallTimeout=0.

Source files
------------

// File: rtl/if_id_pipe_reg_if.sv
// Fetch-to-decode pipeline register bus.
// The master side (fetch/hazard logic) drives the F-stage inputs and control.
// The slave side (the pipeline register) drives the D-stage outputs and debug counters.
interface if_id_pipe_reg_if #(
  parameter int DWL  = 32,
  parameter int CNTW = 16
);
  logic            Stall;
  logic            PCSrcD;
  logic [DWL-1:0]  InstrF;
  logic [DWL-1:0]  PCPlus4F;
  logic [DWL-1:0]  InstrD;
  logic [DWL-1:0]  PCPlus4D;
  logic            ValidD;
  logic [1:0]      StateD;
  logic [CNTW-1:0] StallCnt;
  logic [CNTW-1:0] FlushCnt;
  logic [CNTW-1:0] BubbleCnt;
  logic            StallTimeout;

  modport master (
    output Stall, PCSrcD, InstrF, PCPlus4F,
    input  InstrD, PCPlus4D, ValidD, StateD,
    input  StallCnt, FlushCnt, BubbleCnt, StallTimeout
  );

  modport slave (
    input  Stall, PCSrcD, InstrF, PCPlus4F,
    output InstrD, PCPlus4D, ValidD, StateD,
    output StallCnt, FlushCnt, BubbleCnt, StallTimeout
  );
endinterface

// File: rtl/if_id_pipe_reg.sv
// IF/ID pipeline register with hold/squash control FSM and saturating
// stall, flush and bubble performance counters.
// Optional stall watchdog: define IF_ID_STALL_WATCHDOG_EN to build it in;
// otherwise StallTimeout is tied low and no watchdog logic exists.
module if_id_pipe_reg #(
  parameter int DWL      = 32,
  parameter int CNTW     = 16,
  parameter int WD_LIMIT = 64
) (
  input logic            clk,
  input logic            rst_n,
  if_id_pipe_reg_if.slave bus
);

  typedef enum logic [1:0] {
    RUN    = 2'b00,
    HOLD   = 2'b01,
    SQUASH = 2'b10
  } state_t;

  state_t          state_q, state_d;
  logic [DWL-1:0]  instr_q, instr_d;
  logic [DWL-1:0]  pc4_q, pc4_d;
  logic            valid_q, valid_d;
  logic [CNTW-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNTW-1:0] flush_cnt_q, flush_cnt_d;
  logic [CNTW-1:0] bubble_cnt_q, bubble_cnt_d;
  // The ValidD=0 left by reset is not a pipeline bubble; bubble counting
  // starts once the first edge after reset exit has been taken.
  logic            armed_q, armed_d;

  function automatic logic [CNTW-1:0] sat_inc(input logic [CNTW-1:0] v);
    return (v == {CNTW{1'b1}}) ? v : v + CNTW'(1);
  endfunction

  // Next-state and datapath: Stall beats PCSrcD beats normal capture.
  always_comb begin
    state_d = RUN;
    instr_d = instr_q;
    pc4_d   = pc4_q;
    valid_d = valid_q;
    if (bus.Stall) begin
      // Branch cannot resolve while stalled, so PCSrcD is ignored here.
      state_d = HOLD;
    end else if (bus.PCSrcD) begin
      state_d = SQUASH;
      instr_d = '0;
      pc4_d   = bus.PCPlus4F;
      valid_d = 1'b0;
    end else begin
      state_d = RUN;
      instr_d = bus.InstrF;
      pc4_d   = bus.PCPlus4F;
      valid_d = 1'b1;
    end
  end

  // Performance counters, all evaluated from this edge's inputs and current ValidD.
  always_comb begin
    stall_cnt_d  = stall_cnt_q;
    flush_cnt_d  = flush_cnt_q;
    bubble_cnt_d = bubble_cnt_q;
    armed_d      = 1'b1;
    if (bus.Stall) begin
      stall_cnt_d = sat_inc(stall_cnt_q);
    end
    if (!bus.Stall && bus.PCSrcD) begin
      flush_cnt_d = sat_inc(flush_cnt_q);
    end
    if (armed_q && !valid_q) begin
      bubble_cnt_d = sat_inc(bubble_cnt_q);
    end
  end

  // State, datapath and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= RUN;
      instr_q      <= '0;
      pc4_q        <= '0;
      valid_q      <= 1'b0;
      stall_cnt_q  <= '0;
      flush_cnt_q  <= '0;
      bubble_cnt_q <= '0;
      armed_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      instr_q      <= instr_d;
      pc4_q        <= pc4_d;
      valid_q      <= valid_d;
      stall_cnt_q  <= stall_cnt_d;
      flush_cnt_q  <= flush_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
      armed_q      <= armed_d;
    end
  end

  assign bus.InstrD    = instr_q;
  assign bus.PCPlus4D  = pc4_q;
  assign bus.ValidD    = valid_q;
  assign bus.StateD    = state_q;
  assign bus.StallCnt  = stall_cnt_q;
  assign bus.FlushCnt  = flush_cnt_q;
  assign bus.BubbleCnt = bubble_cnt_q;

`ifdef IF_ID_STALL_WATCHDOG_EN
  localparam int WDW = $clog2(WD_LIMIT + 1);
  localparam logic [WDW-1:0] WD_MAX = WDW'(WD_LIMIT);

  logic [WDW-1:0] wd_cnt_q, wd_cnt_d;
  logic           timeout_q, timeout_d;

  // Count consecutive stalled edges; flag is sticky until reset.
  always_comb begin
    wd_cnt_d  = '0;
    timeout_d = timeout_q;
    if (bus.Stall) begin
      wd_cnt_d = (wd_cnt_q == WD_MAX) ? wd_cnt_q : wd_cnt_q + WDW'(1);
      if (wd_cnt_d == WD_MAX) begin
        timeout_d = 1'b1;
      end
    end
  end

  // Watchdog registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_cnt_q  <= '0;
      timeout_q <= 1'b0;
    end else begin
      wd_cnt_q  <= wd_cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign bus.StallTimeout = timeout_q;
`else
  assign bus.StallTimeout = 1'b0;
`endif

endmodule

// File: tb/tb_if_id_pipe_reg.sv
// Directed self-checking bench for if_id_pipe_reg (CNTW=4, WD_LIMIT=4 so
// saturation and the watchdog are reachable in a few cycles).
module tb_if_id_pipe_reg;
  localparam int DWL  = 32;
  localparam int CNTW = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   pass_cnt = 0;
  int   total_cnt = 0;
  logic exp_to;

  if_id_pipe_reg_if #(.DWL(DWL), .CNTW(CNTW)) bus ();

  if_id_pipe_reg #(.DWL(DWL), .CNTW(CNTW), .WD_LIMIT(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Advance one rising edge and settle away from it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic s, input logic p, input logic [31:0] i, input logic [31:0] pc);
    bus.Stall    = s;
    bus.PCSrcD   = p;
    bus.InstrF   = i;
    bus.PCPlus4F = pc;
  endtask

  task automatic test_reset();
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    rst_n = 1'b0;
    #12;
    total_cnt++; if (bus.InstrD !== 32'h0) $display("FAIL reset_instr got=%h want=%h", bus.InstrD, 32'h0); else pass_cnt++;
    total_cnt++; if (bus.PCPlus4D !== 32'h0) $display("FAIL reset_pc got=%h want=%h", bus.PCPlus4D, 32'h0); else pass_cnt++;
    total_cnt++; if (bus.ValidD !== 1'b0) $display("FAIL reset_valid got=%b want=0", bus.ValidD); else pass_cnt++;
    total_cnt++; if (bus.StateD !== 2'b00) $display("FAIL reset_state got=%b want=00", bus.StateD); else pass_cnt++;
    total_cnt++; if ({bus.StallCnt, bus.FlushCnt, bus.BubbleCnt} !== 12'h0) $display("FAIL reset_cnts got=%h want=000", {bus.StallCnt, bus.FlushCnt, bus.BubbleCnt}); else pass_cnt++;
    total_cnt++; if (bus.StallTimeout !== 1'b0) $display("FAIL reset_timeout got=%b want=0", bus.StallTimeout); else pass_cnt++;
    @(posedge clk);
    #2 rst_n = 1'b1;
    $display("reset released");
  endtask

  task automatic test_free_run();
    drive(1'b0, 1'b0, 32'h8C080004, 32'h00000004);
    step();
    $display("run: InstrD=%h PCPlus4D=%h ValidD=%b StateD=%b", bus.InstrD, bus.PCPlus4D, bus.ValidD, bus.StateD);
    total_cnt++; if (bus.InstrD !== 32'h8C080004) $display("FAIL run1_instr got=%h want=8c080004", bus.InstrD); else pass_cnt++;
    total_cnt++; if (bus.PCPlus4D !== 32'h4) $display("FAIL run1_pc got=%h want=00000004", bus.PCPlus4D); else pass_cnt++;
    total_cnt++; if ({bus.ValidD, bus.StateD} !== 3'b100) $display("FAIL run1_valid_state got=%b want=100", {bus.ValidD, bus.StateD}); else pass_cnt++;
    total_cnt++; if (bus.BubbleCnt !== 4'd0) $display("FAIL run1_bubble got=%0d want=0", bus.BubbleCnt); else pass_cnt++;
    drive(1'b0, 1'b0, 32'h20090005, 32'h00000008);
    step();
    $display("run: InstrD=%h PCPlus4D=%h", bus.InstrD, bus.PCPlus4D);
    total_cnt++; if ({bus.InstrD, bus.PCPlus4D} !== {32'h20090005, 32'h8}) $display("FAIL run2 got=%h/%h want=20090005/00000008", bus.InstrD, bus.PCPlus4D); else pass_cnt++;
  endtask

  task automatic test_stall();
    int seen_old;
    seen_old = 0;
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 1'b0, 32'h11111111 * (k + 1), 32'h100 + 32'(k));
      step();
      $display("stall %0d: InstrD=%h StateD=%b StallCnt=%0d", k, bus.InstrD, bus.StateD, bus.StallCnt);
      total_cnt++; if ({bus.InstrD, bus.PCPlus4D, bus.ValidD} !== {32'h20090005, 32'h8, 1'b1}) $display("FAIL stall_hold%0d got=%h want=20090005", k, bus.InstrD); else pass_cnt++;
      total_cnt++; if (bus.StateD !== 2'b01) $display("FAIL stall_state%0d got=%b want=01", k, bus.StateD); else pass_cnt++;
    end
    total_cnt++; if (bus.StallCnt !== 4'd3) $display("FAIL stall_cnt got=%0d want=3", bus.StallCnt); else pass_cnt++;
    drive(1'b0, 1'b0, 32'h01095020, 32'h0000000C);
    step();
    if (bus.InstrD === 32'h20090005) seen_old++;
    $display("release: InstrD=%h StateD=%b", bus.InstrD, bus.StateD);
    total_cnt++; if ({bus.InstrD, bus.PCPlus4D} !== {32'h01095020, 32'hC}) $display("FAIL release got=%h/%h want=01095020/0000000c", bus.InstrD, bus.PCPlus4D); else pass_cnt++;
    total_cnt++; if ((seen_old !== 0) || (bus.StateD !== 2'b00)) $display("FAIL release_dup got=%0d/%b want=0/00", seen_old, bus.StateD); else pass_cnt++;
  endtask

  task automatic test_squash();
    drive(1'b0, 1'b1, 32'hDEADBEEF, 32'h00000010);
    step();
    $display("squash: InstrD=%h PCPlus4D=%h ValidD=%b StateD=%b Flush=%0d Bubble=%0d", bus.InstrD, bus.PCPlus4D, bus.ValidD, bus.StateD, bus.FlushCnt, bus.BubbleCnt);
    total_cnt++; if ({bus.InstrD, bus.PCPlus4D, bus.ValidD, bus.StateD} !== {32'h0, 32'h10, 1'b0, 2'b10}) $display("FAIL squash1 got=%h/%h/%b/%b want=0/10/0/10", bus.InstrD, bus.PCPlus4D, bus.ValidD, bus.StateD); else pass_cnt++;
    total_cnt++; if ({bus.FlushCnt, bus.BubbleCnt} !== {4'd1, 4'd0}) $display("FAIL squash1_cnt got=%0d/%0d want=1/0", bus.FlushCnt, bus.BubbleCnt); else pass_cnt++;
    // Back-to-back squash: consecutive bubbles, state stays SQUASH.
    drive(1'b0, 1'b1, 32'hCAFEF00D, 32'h00000014);
    step();
    $display("squash2: StateD=%b Flush=%0d Bubble=%0d", bus.StateD, bus.FlushCnt, bus.BubbleCnt);
    total_cnt++; if ({bus.InstrD, bus.ValidD, bus.StateD, bus.PCPlus4D} !== {32'h0, 1'b0, 2'b10, 32'h14}) $display("FAIL squash2 got=%h/%b/%b want=0/0/10", bus.InstrD, bus.ValidD, bus.StateD); else pass_cnt++;
    total_cnt++; if ({bus.FlushCnt, bus.BubbleCnt} !== {4'd2, 4'd1}) $display("FAIL squash2_cnt got=%0d/%0d want=2/1", bus.FlushCnt, bus.BubbleCnt); else pass_cnt++;
    drive(1'b0, 1'b0, 32'hAC0B0000, 32'h00000018);
    step();
    $display("resume: InstrD=%h StateD=%b Bubble=%0d", bus.InstrD, bus.StateD, bus.BubbleCnt);
    total_cnt++; if ({bus.InstrD, bus.ValidD, bus.StateD} !== {32'hAC0B0000, 1'b1, 2'b00}) $display("FAIL resume got=%h/%b/%b want=ac0b0000/1/00", bus.InstrD, bus.ValidD, bus.StateD); else pass_cnt++;
    total_cnt++; if (bus.BubbleCnt !== 4'd2) $display("FAIL resume_bubble got=%0d want=2", bus.BubbleCnt); else pass_cnt++;
  endtask

  task automatic test_stall_and_flush();
    drive(1'b1, 1'b1, 32'h12345678, 32'h0000001C);
    step();
    $display("stall+flush: InstrD=%h StateD=%b Flush=%0d Stall=%0d", bus.InstrD, bus.StateD, bus.FlushCnt, bus.StallCnt);
    total_cnt++; if ({bus.InstrD, bus.ValidD, bus.StateD} !== {32'hAC0B0000, 1'b1, 2'b01}) $display("FAIL stflush got=%h/%b/%b want=ac0b0000/1/01", bus.InstrD, bus.ValidD, bus.StateD); else pass_cnt++;
    total_cnt++; if ({bus.FlushCnt, bus.StallCnt} !== {4'd2, 4'd4}) $display("FAIL stflush_cnt got=%0d/%0d want=2/4", bus.FlushCnt, bus.StallCnt); else pass_cnt++;
    drive(1'b0, 1'b0, 32'h00000020, 32'h00000020);
    step();
  endtask

  task automatic test_watchdog();
`ifdef IF_ID_STALL_WATCHDOG_EN
    exp_to = 1'b1;
`else
    exp_to = 1'b0;
`endif
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 1'b0, 32'h0, 32'h0);
      step();
    end
    $display("watchdog after 3 stalls: StallTimeout=%b", bus.StallTimeout);
    total_cnt++; if (bus.StallTimeout !== 1'b0) $display("FAIL wd_early got=%b want=0", bus.StallTimeout); else pass_cnt++;
    step();
    $display("watchdog after 4 stalls: StallTimeout=%b", bus.StallTimeout);
    total_cnt++; if (bus.StallTimeout !== exp_to) $display("FAIL wd_hit got=%b want=%b", bus.StallTimeout, exp_to); else pass_cnt++;
    drive(1'b0, 1'b0, 32'h00000024, 32'h00000024);
    step();
    $display("watchdog after release: StallTimeout=%b InstrD=%h", bus.StallTimeout, bus.InstrD);
    total_cnt++; if (bus.StallTimeout !== exp_to) $display("FAIL wd_sticky got=%b want=%b", bus.StallTimeout, exp_to); else pass_cnt++;
    total_cnt++; if (bus.StallCnt !== 4'd8) $display("FAIL wd_stallcnt got=%0d want=8", bus.StallCnt); else pass_cnt++;
  endtask

  task automatic test_saturation();
    drive(1'b1, 1'b0, 32'h0, 32'h0);
    for (int k = 0; k < 10; k++) step();
    $display("saturation: StallCnt=%0d", bus.StallCnt);
    total_cnt++; if (bus.StallCnt !== 4'd15) $display("FAIL sat_stall got=%0d want=15", bus.StallCnt); else pass_cnt++;
  endtask

  task automatic test_async_reset();
    // Still stalled from the previous test: sitting in HOLD.
    total_cnt++; if (bus.StateD !== 2'b01) $display("FAIL arst_pre got=%b want=01", bus.StateD); else pass_cnt++;
    #2 rst_n = 1'b0;
    #1;
    $display("async reset: InstrD=%h StateD=%b ValidD=%b Stall=%0d", bus.InstrD, bus.StateD, bus.ValidD, bus.StallCnt);
    total_cnt++; if ({bus.InstrD, bus.PCPlus4D, bus.ValidD, bus.StateD} !== {32'h0, 32'h0, 1'b0, 2'b00}) $display("FAIL arst_out got=%h/%h/%b/%b want=0/0/0/00", bus.InstrD, bus.PCPlus4D, bus.ValidD, bus.StateD); else pass_cnt++;
    total_cnt++; if ({bus.StallCnt, bus.FlushCnt, bus.BubbleCnt, bus.StallTimeout} !== 13'h0) $display("FAIL arst_cnt got=%h want=0", {bus.StallCnt, bus.FlushCnt, bus.BubbleCnt, bus.StallTimeout}); else pass_cnt++;
    drive(1'b0, 1'b0, 32'h8C080004, 32'h00000004);
    step();
    rst_n = 1'b1;
    step();
    $display("post-reset run: InstrD=%h ValidD=%b Bubble=%0d", bus.InstrD, bus.ValidD, bus.BubbleCnt);
    total_cnt++; if ({bus.InstrD, bus.ValidD, bus.BubbleCnt} !== {32'h8C080004, 1'b1, 4'd0}) $display("FAIL arst_rerun got=%h/%b/%0d want=8c080004/1/0", bus.InstrD, bus.ValidD, bus.BubbleCnt); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_free_run();
    test_stall();
    test_squash();
    test_stall_and_flush();
    test_watchdog();
    test_saturation();
    test_async_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL sim_timeout got=running want=finished");
    $fatal(1, "simulation time limit");
  end
endmodule
